// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use, taken-branch, MDU occupancy and memory wait handling.
// Optional stall-cycle performance counter enabled by PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl #(
   parameter int MDU_LAT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic       ex_memread,
   input  logic [4:0] ex_rt,
   input  logic       ex_branch_taken,
   input  logic       ex_mdu_start,
   input  logic       mem_wait,
   output logic       pc_stall,
   output logic       ifid_stall,
   output logic       ifid_flush,
   output logic       idex_stall,
   output logic       idex_flush,
   output logic       exmem_flush,
   output logic       exmem_stall,
   output logic       mdu_busy,
   output logic       mdu_done,
   output logic [1:0] state
`ifdef PIPE_CTRL_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles
`endif
);

   // state    | meaning
   // RUN      | normal issue, MDU idle
   // MDU_WAIT | mul/div occupying EX, counter running
   // MDU_DONE | result valid this cycle
   // ILLEGAL  | unused code, recovers to RUN
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MDU_WAIT = 2'd1,
      MDU_DONE = 2'd2,
      ILLEGAL  = 2'd3
   } state_t;

   localparam logic [5:0] CNT_LOAD = 6'(MDU_LAT - 2);

   state_t     r_state;
   logic [5:0] r_cnt;
   logic       w_load_use;
   logic       w_busy;

   assign w_load_use = ex_memread && (ex_rt != 5'd0) &&
                       ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
   assign w_busy     = !rst && ((r_state == MDU_WAIT) || ((r_state == RUN) && ex_mdu_start));

   assign mdu_busy = w_busy;
   assign mdu_done = !rst && (r_state == MDU_DONE);
   assign state    = r_state;

   always_comb begin
      pc_stall    = 1'b0;
      ifid_stall  = 1'b0;
      ifid_flush  = 1'b0;
      idex_stall  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      exmem_stall = 1'b0;
      if (!rst) begin
         if (mem_wait) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
         end else if (w_busy) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
         end else if (ex_branch_taken) begin
            // a taken branch makes any stalled ID instruction wrong-path
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
         end else if (w_load_use) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= RUN;
         r_cnt   <= 6'd0;
      end else if (!mem_wait) begin
         case (r_state)
            RUN: begin
               if (ex_mdu_start) begin
                  r_state <= MDU_WAIT;
                  r_cnt   <= CNT_LOAD;
               end
            end
            MDU_WAIT: begin
               // reaching zero on this decrement ends the wait
               if (r_cnt <= 6'd1) begin
                  r_state <= MDU_DONE;
                  r_cnt   <= 6'd0;
               end else begin
                  r_cnt <= r_cnt - 6'd1;
               end
            end
            MDU_DONE: r_state <= RUN;
            default:  r_state <= RUN;
         endcase
      end
   end

`ifdef PIPE_CTRL_PERF_CNT_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles <= 32'd0;
      end else if (pc_stall) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
